// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, sequencer state type and width helpers
// used by the mixer and its gain ramp.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } mix_state_t;

    // Accumulator must hold NUM_CH full-scale samples without wrapping.
    function automatic int acc_width(input int num_ch);
        return SAMPLE_W + $clog2(num_ch);
    endfunction

    // Gain runs 0..GAIN_MAX inclusive, so one bit more than log2(GAIN_MAX).
    function automatic int gain_width(input int gain_max);
        return $clog2(gain_max) + 1;
    endfunction

endpackage

// File: rtl/sound_gain_ramp.sv
// Soft-mute gain counter that steps once per produced sample, plus the
// gain multiply applied to the saturated mix.
module sound_gain_ramp
    import audio_pkg::*;
#(
    parameter int GAIN_MAX = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             step,
    input  logic                             dir_up,
    input  logic [SAMPLE_W-1:0]              sample,
    output logic [gain_width(GAIN_MAX)-1:0]  gain,
    output logic [SAMPLE_W-1:0]              scaled
);

    localparam int GW    = gain_width(GAIN_MAX);
    localparam int SHIFT = $clog2(GAIN_MAX);
    localparam int PW    = SAMPLE_W + SHIFT;
    localparam logic [GW-1:0] GAIN_TOP = GW'(GAIN_MAX);

    logic [PW-1:0] product;

    always_ff @(posedge clk) begin
        if (rst) begin
            gain <= '0;
        end else if (step) begin
            if (dir_up && gain != GAIN_TOP) begin
                gain <= gain + 1'b1;
            end else if (!dir_up && gain != '0) begin
                gain <= gain - 1'b1;
            end
        end
    end

    // gain never exceeds GAIN_MAX, so the product fits in SAMPLE_W+SHIFT bits.
    always_comb begin
        product = PW'(sample) * PW'(gain);
        scaled  = SAMPLE_W'(product >> SHIFT);
    end

endmodule

// File: rtl/sound_mix_sequencer.sv
// Sequential channel mixer: on each sample tick, sums enabled channels one per
// clock, saturates to 16 bits and applies the soft-mute gain.
module sound_mix_sequencer
    import audio_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int GAIN_MAX = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_6KHz_en,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]                ch_en,
    input  logic                             sound_enable,
    output logic [SAMPLE_W-1:0]              out,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int ACC_W = acc_width(NUM_CH);
    localparam int GW    = gain_width(GAIN_MAX);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_t state, state_next;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] shadow_data;
    logic [NUM_CH-1:0]               shadow_en;
    logic                            shadow_snd_en;
    logic [ACC_W-1:0]                acc;
    logic [ACC_W-1:0]                addend;
    logic [IDX_W-1:0]                idx;
    logic [SAMPLE_W-1:0]             sat_value;
    logic [SAMPLE_W-1:0]             scaled;
    logic [GW-1:0]                   gain;
    logic                            gain_step;

    sound_gain_ramp #(
        .GAIN_MAX (GAIN_MAX)
    ) u_gain_ramp (
        .clk    (clk),
        .rst    (rst),
        .step   (gain_step),
        .dir_up (shadow_snd_en),
        .sample (sat_value),
        .gain   (gain),
        .scaled (scaled)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clk_6KHz_en) state_next = ACC;
            ACC:     if (idx == LAST_IDX) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        gain_step = (state == SAT);
        addend    = shadow_en[idx] ? ACC_W'(shadow_data[idx]) : '0;
        sat_value = (acc > ACC_W'(SAMPLE_MAX)) ? SAMPLE_MAX : acc[SAMPLE_W-1:0];
    end

    // Inputs are only looked at on an idle tick; everything after works from shadows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shadow_data   <= '0;
            shadow_en     <= '0;
            shadow_snd_en <= 1'b0;
            acc           <= '0;
            idx           <= '0;
            out           <= '0;
            out_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state == SAT);
            if (clk_6KHz_en && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clk_6KHz_en) begin
                        shadow_data   <= ch_data;
                        shadow_en     <= ch_en;
                        shadow_snd_en <= sound_enable;
                        acc           <= '0;
                        idx           <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + addend;
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                SAT: begin
                    // Explicit zero path keeps a fully muted output at exactly zero.
                    out <= (gain == '0) ? '0 : scaled;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sound_mix_sequencer.md
SOUND_MIX_SEQUENCER -- requirements
Module: sound_mix_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of mixed source channels (2..8).
REQ-002 The block SHALL have parameter GAIN_MAX, default 8, meaning full-scale soft-mute gain (power of two).
REQ-003 The block SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port clk_6KHz_en  input  1  one-cycle sample tick.
REQ-006 The block SHALL have port ch_data  input  NUM_CH x 16  unsigned channel samples (POKEY-scaled, analog sources).
REQ-007 The block SHALL have port ch_en  input  NUM_CH  per-channel enable (from output latch bits).
REQ-008 The block SHALL have port sound_enable  input  1  master sound enable.
REQ-009 The block SHALL have port out  output  16  mixed unsigned sample.
REQ-010 The block SHALL have port out_valid  output  1  one-cycle strobe, out updated.
REQ-011 The block SHALL have port busy  output  1  high while state != IDLE.
REQ-012 The block SHALL have port overrun  output  1  sticky flag, tick arrived while busy.

Function
REQ-013 FSM states SHALL be IDLE, ACC, SAT; busy = (state != IDLE).
REQ-014 In IDLE with clk_6KHz_en=1: capture ch_data, ch_en, sound_enable into shadow registers; acc <= 0; idx <= 0; go ACC.
REQ-015 ACC: one channel per cycle, acc <= acc + (shadow_en[idx] ? shadow_data[idx] : 0); idx increments; after idx = NUM_CH-1 go SAT.
REQ-016 acc width SHALL be 16 + clog2(NUM_CH) bits; no overflow inside ACC.
REQ-017 SAT: sat = min(acc, 16'hFFFF); out <= (sat * gain) >> clog2(GAIN_MAX), truncated; out_valid <= 1 for exactly one cycle; go IDLE.
REQ-018 Latency: tick sampled at edge E0 -> out/out_valid visible after edge E0+NUM_CH+1 (5 clocks at NUM_CH=4).
REQ-019 out SHALL hold its value between updates; out_valid SHALL be 0 except the cycle after SAT.
REQ-020 Gain ramp: at each SAT, gain steps by 1 toward GAIN_MAX if shadow sound_enable=1, toward 0 otherwise; saturates at ends; new gain applies from the next sample (SAT uses pre-step gain).
REQ-021 Ticks while busy (ACC or SAT) SHALL be ignored, set overrun=1; sample in flight completes unchanged.
REQ-022 Changes on ch_data/ch_en/sound_enable while busy SHALL NOT affect the in-flight sample.
REQ-023 gain=0 SHALL give out=0 regardless of channels.

Reset
REQ-024 rst=1 at any edge, including mid-ACC/SAT: state=IDLE, acc=0, idx=0, gain=0, out=0, out_valid=0, overrun=0, shadows=0; in-flight sample discarded, no out_valid.
REQ-025 Tick coincident with rst SHALL be ignored.

Structure
REQ-026 Shared package audio_pkg SHALL hold SAMPLE_W=16, state enum type, and gain-width/ACC-width helper constants.
REQ-027 Gain ramp counter and multiply SHALL be sub-module sound_gain_ramp (step, direction, gain out); accumulator sequencing stays in top.

Verification
REQ-028 Ramp-up: sound_enable=1, ch_en=0001, ch0=0x4000, 9 ticks -> outs 0x0000,0x0800,0x1000,...,0x4000 (gain 0..8), then steady 0x4000.
REQ-029 Saturation: gain=8, all four channels 0x7800 enabled -> acc=0x1E000, out=0xFFFF.
REQ-030 Enable mask: ch=0x1000,0x2000,0x3000,0x4000, ch_en=1010, gain=8 -> out=0x6000, out_valid exactly 5 clocks after tick.
REQ-031 Overrun: second tick 2 clocks after first -> overrun=1 sticky, single out_valid, value from first sample.
REQ-032 Mute fade: at gain=8 drop sound_enable -> outs scale 8/8,7/8,...,1/8, then 0 forever.
REQ-033 Reset mid-ACC (rst at clock 2 after tick) -> no out_valid, out=0, gain=0, overrun=0, next tick runs normally.
